// File: rtl/keypad_pkg.sv
// Shared key codes, sizing constants and the keypad matrix map.
package keypad_pkg;

    localparam int unsigned DIGITS_MAX = 4;
    localparam int unsigned ENTRY_W    = 16;
    localparam int unsigned DIGITS_W   = 3;
    localparam int unsigned SNAP_W     = 16;

    localparam logic [3:0] KEY_0    = 4'h0;
    localparam logic [3:0] KEY_1    = 4'h1;
    localparam logic [3:0] KEY_2    = 4'h2;
    localparam logic [3:0] KEY_3    = 4'h3;
    localparam logic [3:0] KEY_4    = 4'h4;
    localparam logic [3:0] KEY_5    = 4'h5;
    localparam logic [3:0] KEY_6    = 4'h6;
    localparam logic [3:0] KEY_7    = 4'h7;
    localparam logic [3:0] KEY_8    = 4'h8;
    localparam logic [3:0] KEY_9    = 4'h9;
    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_BKSP = 4'hB;
    localparam logic [3:0] KEY_CLR  = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hD;
    localparam logic [3:0] KEY_ENT  = 4'hE;
    localparam logic [3:0] KEY_F    = 4'hF;

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2,
        COL3 = 2'd3
    } col_state_e;

    // PmodKYPD legend: rows [1 2 3 A][4 5 6 B][7 8 9 C][0 F E D]
    function automatic logic [3:0] key_code(input logic [1:0] col_idx, input logic [1:0] row_idx);
        logic [3:0] code;
        case ({row_idx, col_idx})
            4'h0:    code = KEY_1;
            4'h1:    code = KEY_2;
            4'h2:    code = KEY_3;
            4'h3:    code = KEY_A;
            4'h4:    code = KEY_4;
            4'h5:    code = KEY_5;
            4'h6:    code = KEY_6;
            4'h7:    code = KEY_BKSP;
            4'h8:    code = KEY_7;
            4'h9:    code = KEY_8;
            4'hA:    code = KEY_9;
            4'hB:    code = KEY_CLR;
            4'hC:    code = KEY_0;
            4'hD:    code = KEY_F;
            4'hE:    code = KEY_ENT;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column strobing, row sampling and full-scan debounce; emits one pulse per clean single-key press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_TICKS     = 65536,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       press_valid,
    output logic [3:0] press_code
);

    localparam int unsigned TICK_W  = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int unsigned MATCH_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(SCAN_TICKS - 1);
    localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(DEBOUNCE_SCANS);

    col_state_e          col_state, col_state_nxt;
    logic [TICK_W-1:0]   tick_cnt, tick_nxt;
    logic [11:0]         snap_q, snap_nxt;
    logic [SNAP_W-1:0]   prev_snap, prev_nxt;
    logic [MATCH_W-1:0]  match_cnt, match_nxt;
    logic [SNAP_W-1:0]   stable, stable_nxt;
    logic [3:0]          col_nxt;
    logic                press_valid_nxt;
    logic [3:0]          press_code_nxt;
    logic                col_last;
    logic [SNAP_W-1:0]   full_snap;
    logic                snap_one_hot;
    logic [3:0]          hit_code;

    // Column 3 bits come straight from the rows in its sampling cycle
    assign full_snap    = {~row, snap_q};
    assign col_last     = (tick_cnt == TICK_LAST);
    assign snap_one_hot = (full_snap != '0) && ((full_snap & (full_snap - SNAP_W'(1))) == '0);

    // Bit 4*c+r of a snapshot is column c, row r
    always_comb begin
        hit_code = KEY_0;
        for (int i = 0; i < 16; i++) begin
            if (full_snap[i]) begin
                hit_code = key_code(2'(i / 4), 2'(i % 4));
            end
        end
    end

    always_comb begin
        col_state_nxt   = col_state;
        tick_nxt        = col_last ? '0 : tick_cnt + TICK_W'(1);
        snap_nxt        = snap_q;
        prev_nxt        = prev_snap;
        match_nxt       = match_cnt;
        stable_nxt      = stable;
        press_valid_nxt = 1'b0;
        press_code_nxt  = press_code;
        col_nxt         = 4'b1110;

        if (col_last) begin
            case (col_state)
                COL0: begin
                    snap_nxt[3:0] = ~row;
                    col_state_nxt = COL1;
                end
                COL1: begin
                    snap_nxt[7:4] = ~row;
                    col_state_nxt = COL2;
                end
                COL2: begin
                    snap_nxt[11:8] = ~row;
                    col_state_nxt  = COL3;
                end
                default: begin
                    col_state_nxt = COL0;
                    prev_nxt      = full_snap;
                    if (full_snap == prev_snap) begin
                        match_nxt = (match_cnt == MATCH_MAX) ? match_cnt : match_cnt + MATCH_W'(1);
                    end else begin
                        match_nxt = MATCH_W'(1);
                    end
                    // Press only from an idle stable set; multi-key and key-to-key moves stay silent
                    if (match_nxt >= MATCH_MAX) begin
                        stable_nxt = full_snap;
                        if ((stable == '0) && snap_one_hot) begin
                            press_valid_nxt = 1'b1;
                            press_code_nxt  = hit_code;
                        end
                    end
                end
            endcase
        end

        case (col_state_nxt)
            COL0:    col_nxt = 4'b1110;
            COL1:    col_nxt = 4'b1101;
            COL2:    col_nxt = 4'b1011;
            default: col_nxt = 4'b0111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_state   <= COL0;
            tick_cnt    <= '0;
            snap_q      <= '0;
            prev_snap   <= '0;
            match_cnt   <= '0;
            stable      <= '0;
            col         <= 4'b1110;
            press_valid <= 1'b0;
            press_code  <= KEY_0;
        end else begin
            col_state   <= col_state_nxt;
            tick_cnt    <= tick_nxt;
            snap_q      <= snap_nxt;
            prev_snap   <= prev_nxt;
            match_cnt   <= match_nxt;
            stable      <= stable_nxt;
            col         <= col_nxt;
            press_valid <= press_valid_nxt;
            press_code  <= press_code_nxt;
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// Four-digit decimal keypad entry with backspace, clear and enter-to-commit.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_TICKS     = 65536,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [15:0] entry,
    output logic [2:0]  digits,
    output logic [15:0] key,
    output logic        key_valid
);

    logic                press_valid;
    logic [3:0]          press_code;
    logic [ENTRY_W-1:0]  entry_nxt;
    logic [DIGITS_W-1:0] digits_nxt;
    logic [ENTRY_W-1:0]  key_nxt;
    logic                key_valid_nxt;

    keypad_scanner #(
        .SCAN_TICKS     (SCAN_TICKS),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_scanner (
        .clk         (clk),
        .rst         (rst),
        .row         (row),
        .col         (col),
        .press_valid (press_valid),
        .press_code  (press_code)
    );

    always_comb begin
        entry_nxt     = entry;
        digits_nxt    = digits;
        key_nxt       = key;
        key_valid_nxt = 1'b0;

        if (press_valid) begin
            if (press_code <= KEY_9) begin
                // Shift-add times ten; a fifth digit is dropped
                if (digits < DIGITS_W'(DIGITS_MAX)) begin
                    entry_nxt  = (entry << 3) + (entry << 1) + ENTRY_W'(press_code);
                    digits_nxt = digits + DIGITS_W'(1);
                end
            end else begin
                case (press_code)
                    KEY_BKSP: begin
                        if (digits != '0) begin
                            entry_nxt  = entry / ENTRY_W'(10);
                            digits_nxt = digits - DIGITS_W'(1);
                        end
                    end
                    KEY_CLR: begin
                        entry_nxt  = '0;
                        digits_nxt = '0;
                    end
                    KEY_ENT: begin
                        key_nxt       = entry;
                        key_valid_nxt = 1'b1;
                        entry_nxt     = '0;
                        digits_nxt    = '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry     <= '0;
            digits    <= '0;
            key       <= '0;
            key_valid <= 1'b0;
        end else begin
            entry     <= entry_nxt;
            digits    <= digits_nxt;
            key       <= key_nxt;
            key_valid <= key_valid_nxt;
        end
    end

endmodule
